// File: rtl/simon_sequencer.sv
// ============================================================================
// Module   : simon_sequencer
// Purpose  : Simon game round controller. It grows an LFSR-driven colour
//            sequence, shows it as timed presses and checks the player's replay.
// Options  : `define SIMON_TIMEOUT_EN to end the game on player inactivity.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module simon_sequencer #(
  parameter int         MAX_LEN       = 16,
  parameter int         HOLD_TICKS    = 30,
  parameter int         GAP_TICKS     = 30,
  parameter int         TIMEOUT_TICKS = 300,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] playerNum,
  input  logic       playerPressed,
  output logic       simonTurn,
  output logic [1:0] simonNum,
  output logic       simonPressed,
  output logic [4:0] level,
  output logic       gameOver,
  output logic       win
);

  localparam int c_HG   = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
  localparam int c_MAXT = (c_HG > TIMEOUT_TICKS) ? c_HG : TIMEOUT_TICKS;
  localparam int c_TW   = $clog2(c_MAXT + 1);
  localparam int c_IW   = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] c_SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  localparam logic [2:0] c_S_IDLE     = 3'd0;
  localparam logic [2:0] c_S_EXTEND   = 3'd1;
  localparam logic [2:0] c_S_SHOW_ON  = 3'd2;
  localparam logic [2:0] c_S_SHOW_OFF = 3'd3;
  localparam logic [2:0] c_S_LISTEN   = 3'd4;
  localparam logic [2:0] c_S_OVER     = 3'd5;
  localparam logic [2:0] c_S_WIN      = 3'd6;

  logic [2:0]      r_state;
  logic [1:0]      r_seq [MAX_LEN];
  // One extra bit so that MAX_LEN=32 is representable without wrapping.
  logic [5:0]      r_len;
  logic [4:0]      r_idx;
  logic [c_TW-1:0] r_tcnt;
  logic [7:0]      r_lfsr;
  logic            r_startQ;
  logic            r_pressQ;
  logic [1:0]      r_numQ;

  logic [2:0]      w_stateNext;
  logic [5:0]      w_lenNext;
  logic [4:0]      w_idxNext;
  logic [c_TW-1:0] w_tcntNext;
  logic            w_seqWe;
  logic            w_lastIdx;
  logic            w_lfsrFb;
  logic [1:0]      w_showNum;
  logic            w_startOk;

  assign w_lfsrFb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_lastIdx = ({1'b0, r_idx} == (r_len - 6'd1));
  assign w_startOk = (r_state == c_S_IDLE) || (r_state == c_S_OVER) || (r_state == c_S_WIN);

  always_comb begin
    w_stateNext = r_state;
    w_lenNext   = r_len;
    w_idxNext   = r_idx;
    w_tcntNext  = r_tcnt + c_TW'(1);
    w_seqWe     = 1'b0;
    case (r_state)
      c_S_IDLE, c_S_OVER, c_S_WIN: begin
        if (r_startQ) begin
          w_lenNext   = 6'd0;
          w_tcntNext  = '0;
          w_stateNext = c_S_EXTEND;
        end
      end
      c_S_EXTEND: begin
        w_seqWe     = 1'b1;
        w_lenNext   = r_len + 6'd1;
        w_idxNext   = 5'd0;
        w_tcntNext  = '0;
        w_stateNext = c_S_SHOW_ON;
      end
      c_S_SHOW_ON: begin
        if (r_tcnt == c_TW'(HOLD_TICKS - 1)) begin
          w_tcntNext  = '0;
          w_stateNext = c_S_SHOW_OFF;
        end
      end
      c_S_SHOW_OFF: begin
        if (r_tcnt == c_TW'(GAP_TICKS - 1)) begin
          w_tcntNext = '0;
          if (w_lastIdx) begin
            w_idxNext   = 5'd0;
            w_stateNext = c_S_LISTEN;
          end else begin
            w_idxNext   = r_idx + 5'd1;
            w_stateNext = c_S_SHOW_ON;
          end
        end
      end
      c_S_LISTEN: begin
        // A press always wins over a coincident timeout.
        if (r_pressQ) begin
          w_tcntNext = '0;
          if (r_numQ != r_seq[r_idx[c_IW-1:0]]) begin
            w_stateNext = c_S_OVER;
          end else if (w_lastIdx) begin
            w_stateNext = (r_len == 6'(MAX_LEN)) ? c_S_WIN : c_S_EXTEND;
          end else begin
            w_idxNext = r_idx + 5'd1;
          end
        end
`ifdef SIMON_TIMEOUT_EN
        else if (r_tcnt == c_TW'(TIMEOUT_TICKS - 1)) begin
          w_tcntNext  = '0;
          w_stateNext = c_S_OVER;
        end
`endif
      end
      default: begin
        w_stateNext = c_S_IDLE;
      end
    endcase
  end

  // The element just being written is forwarded so round 1 shows it at once.
  assign w_showNum = (w_seqWe && (w_idxNext[c_IW-1:0] == r_len[c_IW-1:0]))
                   ? r_lfsr[1:0] : r_seq[w_idxNext[c_IW-1:0]];

  always_ff @(posedge clk) begin
    if (w_seqWe) begin
      r_seq[r_len[c_IW-1:0]] <= r_lfsr[1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= c_S_IDLE;
      r_len        <= 6'd0;
      r_idx        <= 5'd0;
      r_tcnt       <= '0;
      r_lfsr       <= c_SEED;
      r_startQ     <= 1'b0;
      r_pressQ     <= 1'b0;
      r_numQ       <= 2'd0;
      simonTurn    <= 1'b0;
      simonNum     <= 2'd0;
      simonPressed <= 1'b0;
      level        <= 5'd0;
      gameOver     <= 1'b0;
      win          <= 1'b0;
    end else begin
      r_lfsr   <= {r_lfsr[6:0], w_lfsrFb};
      // Inputs are captured only in the states where they are honoured.
      r_startQ <= start && w_startOk;
      r_pressQ <= playerPressed && (r_state == c_S_LISTEN);
      r_numQ   <= playerNum;
      r_state  <= w_stateNext;
      r_len    <= w_lenNext;
      r_idx    <= w_idxNext;
      r_tcnt   <= w_tcntNext;
      simonTurn    <= (w_stateNext == c_S_EXTEND) || (w_stateNext == c_S_SHOW_ON) ||
                      (w_stateNext == c_S_SHOW_OFF);
      simonPressed <= (w_stateNext == c_S_SHOW_ON);
      if ((w_stateNext == c_S_SHOW_ON) && (r_state != c_S_SHOW_ON)) begin
        simonNum <= w_showNum;
      end
      level    <= w_lenNext[4:0];
      gameOver <= (w_stateNext == c_S_OVER);
      win      <= (w_stateNext == c_S_WIN);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_simon_sequencer.sv
// ============================================================================
// Module   : tb_simon_sequencer
// Purpose  : Directed self-checking bench for simon_sequencer with an LFSR
//            reference model feeding an expected-sequence scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_simon_sequencer;

  localparam int         c_MAX  = 4;
  localparam int         c_HOLD = 2;
  localparam int         c_GAP  = 1;
  localparam int         c_TO   = 5;
  localparam logic [7:0] c_SEED = 8'hA5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] playerNum = 2'd0;
  logic       playerPressed = 1'b0;
  logic       simonTurn;
  logic [1:0] simonNum;
  logic       simonPressed;
  logic [4:0] level;
  logic       gameOver;
  logic       win;

  int nVec = 0;
  int nErr = 0;

  logic [1:0] expSeq[$];
  logic [1:0] showQ[$];
  logic [7:0] m_lfsr;
  logic       m_prevTurn;

  simon_sequencer #(
    .MAX_LEN(c_MAX), .HOLD_TICKS(c_HOLD), .GAP_TICKS(c_GAP),
    .TIMEOUT_TICKS(c_TO), .LFSR_SEED(c_SEED)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .playerNum(playerNum),
    .playerPressed(playerPressed), .simonTurn(simonTurn), .simonNum(simonNum),
    .simonPressed(simonPressed), .level(level), .gameOver(gameOver), .win(win)
  );

  always #5 clk = ~clk;

  // Reference LFSR; an EXTEND cycle (turn rises without a press) appends lfsr[1:0].
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_lfsr     <= c_SEED;
      m_prevTurn <= 1'b0;
    end else begin
      if (simonTurn && !simonPressed && !m_prevTurn) expSeq.push_back(m_lfsr[1:0]);
      m_prevTurn <= simonTurn;
      m_lfsr     <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic press(input logic [1:0] val);
    playerNum     = val;
    playerPressed = 1'b1;
    @(negedge clk);
    playerPressed = 1'b0;
    @(negedge clk);
  endtask

  task automatic watchShow(input int n);
    int w;
    int hi;
    int lo;
    logic [1:0] e;
    w = 0;
    while (!simonPressed && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("showStart", simonPressed, 1);
    showQ = expSeq;
    chk("seqLen", showQ.size(), n);
    chk("level", level, n);
    for (int i = 0; i < n; i++) begin
      e = (showQ.size() > 0) ? showQ.pop_front() : 2'd0;
      chk("simonNum", simonNum, e);
      chk("turnShow", simonTurn, 1);
      hi = 0;
      while (simonPressed && hi < 10) begin
        @(negedge clk);
        hi++;
      end
      chk("holdLen", hi, c_HOLD);
      lo = 0;
      while (!simonPressed && simonTurn && lo < 10) begin
        @(negedge clk);
        lo++;
      end
      chk("gapLen", lo, c_GAP);
    end
    chk("turnListen", simonTurn, 0);
  endtask

  initial begin
    #1 reset = 1'b0;
    cyc(3);
    chk("rstTurn", simonTurn, 0);
    chk("rstNum", simonNum, 0);
    chk("rstPressed", simonPressed, 0);
    chk("rstLevel", level, 0);
    chk("rstOver", gameOver, 0);
    chk("rstWin", win, 0);
    reset = 1'b1;
    cyc(6);

    // Start latency: turn one edge after sampling, press the edge after that.
    expSeq.delete();
    pulseStart();
    chk("turnEdgeN", simonTurn, 0);
    @(negedge clk);
    chk("turnEdgeN1", simonTurn, 1);
    chk("pressEdgeN1", simonPressed, 0);
    @(negedge clk);
    chk("pressEdgeN2", simonPressed, 1);

    // Full game to a win.
    for (int r = 1; r <= c_MAX; r++) begin
      watchShow(r);
      for (int i = 0; i < r; i++) press(expSeq[i]);
      if (r < c_MAX) begin
        chk("extendTurn", simonTurn, 1);
        chk("extendPressed", simonPressed, 0);
      end
    end
    chk("winFlag", win, 1);
    chk("winOver", gameOver, 0);
    chk("winTurn", simonTurn, 0);
    chk("winLevel", level, c_MAX);

    // New game from WIN, wrong answer on the 2nd element of round 3.
    expSeq.delete();
    pulseStart();
    for (int r = 1; r <= 2; r++) begin
      watchShow(r);
      for (int i = 0; i < r; i++) press(expSeq[i]);
    end
    chk("winCleared", win, 0);
    watchShow(3);
    press(expSeq[0]);
    chk("overBefore", gameOver, 0);
    press(expSeq[1] + 2'd1);
    chk("overFlag", gameOver, 1);
    chk("overLevel", level, 3);
    chk("overTurn", simonTurn, 0);
    press(expSeq[2]);
    press(expSeq[1] + 2'd1);
    chk("overSticky", gameOver, 1);
    chk("overLevelHold", level, 3);
    chk("overTurnHold", simonTurn, 0);

    // Restart from OVER, then reset asynchronously while a colour is shown.
    expSeq.delete();
    pulseStart();
    watchShow(1);
    chk("restartOver", gameOver, 0);
    press(expSeq[0]);
    begin
      int w;
      w = 0;
      while (!simonPressed && w < 20) begin
        @(negedge clk);
        w++;
      end
    end
    chk("midShowOn", simonPressed, 1);
    #2 reset = 1'b0;
    #1;
    chk("arstTurn", simonTurn, 0);
    chk("arstNum", simonNum, 0);
    chk("arstPressed", simonPressed, 0);
    chk("arstLevel", level, 0);
    chk("arstOver", gameOver, 0);
    chk("arstWin", win, 0);
    @(negedge clk);
    reset = 1'b1;
    expSeq.delete();
    cyc(2);

    // Inactivity in LISTEN.
    pulseStart();
    watchShow(1);
`ifdef SIMON_TIMEOUT_EN
    begin
      int n;
      n = 0;
      while (!gameOver && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("timeoutCycles", n, c_TO);
      chk("timeoutOver", gameOver, 1);
    end
`else
    cyc(1000);
    chk("noTimeoutOver", gameOver, 0);
    chk("noTimeoutTurn", simonTurn, 0);
    chk("noTimeoutLevel", level, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
